// File: rtl/core_fetch_bus_pkg.sv
// Shared types for the instruction-fetch bus sequencer: word/pointer widths
// and the fetch FSM state encoding.
package core_fetch_bus_pkg;

    localparam int WORD_W = 32;
    localparam int PTR_W  = 30;

    typedef logic [WORD_W-1:0] word;
    typedef logic [PTR_W-1:0]  ptr;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_WAIT,
        FETCH_DISCARD
    } fetch_state;

endpackage

// File: rtl/core_fetch_bus.sv
// Instruction-fetch bus sequencer: turns the prefetch buffer's fetch request into
// single-outstanding word reads and handles branch redirects / stale-read discard.
module core_fetch_bus
    import core_fetch_bus_pkg::*;
#(
    parameter logic [PTR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch,
    input  logic              branch,
    input  logic [PTR_W-1:0]  branch_target,
    input  logic              bus_ready,
    input  logic [WORD_W-1:0] bus_data,
    output logic              bus_start,
    output logic [PTR_W-1:0]  bus_addr,
    output logic              fetched,
    output logic [WORD_W-1:0] fetch_data,
    output logic              flush,
    output logic [PTR_W-1:0]  head
);

    fetch_state state, state_d;
    ptr         fetch_pc, pc_d;
    logic       start_d;

    // State register plus the fetch datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state     <= FETCH_IDLE;
            fetch_pc  <= RESET_PC;
            bus_addr  <= RESET_PC;
            bus_start <= 1'b0;
        end else begin
            state     <= state_d;
            fetch_pc  <= pc_d;
            bus_start <= start_d;
            if (start_d) begin
                bus_addr <= fetch_pc;
            end
        end
    end

    // Next-state logic; a branch always wins over the sequential increment.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a latch.
        state_d = state;
        pc_d    = fetch_pc;
        start_d = 1'b0;
        unique case (state)
            FETCH_IDLE: begin
                if (fetch && !branch) begin
                    state_d = FETCH_WAIT;
                    start_d = 1'b1;
                end
            end
            FETCH_WAIT: begin
                if (bus_ready) begin
                    state_d = FETCH_IDLE;
                    if (!branch) begin
                        pc_d = fetch_pc + PTR_W'(1);
                    end
                end else if (branch) begin
                    state_d = FETCH_DISCARD;
                end
            end
            FETCH_DISCARD: begin
                if (bus_ready) begin
                    state_d = FETCH_IDLE;
                end
            end
            default: state_d = FETCH_IDLE;
        endcase
        if (branch) begin
            pc_d = branch_target;
        end
    end

    // Same-cycle outputs toward the prefetch buffer.
    always_comb begin
        fetched = (state == FETCH_WAIT) && bus_ready && !branch;
        flush   = branch;
        head    = branch ? branch_target : fetch_pc;
    end

    assign fetch_data = bus_data;

    // A completion with no read outstanding means the bus and sequencer disagree.
    a_ready_only_when_outstanding: assert property (
        @(posedge clk) disable iff (!rst_n) bus_ready |-> (state != FETCH_IDLE)
    );

endmodule
